// File: rtl/mem_access_stage.sv
// MEM pipeline stage: unpacks the EX/MEM bundle, runs a req/ack data-memory access,
// resolves branches and produces a registered MEM/WB result plus an upstream stall.
module mem_access_stage #(
    parameter int unsigned N       = 24,
    parameter int unsigned BW      = 16 + 2 * N,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [BW-1:0] exMemIn,
    input  logic          inValid,
    output logic          stall,
    output logic          dmemReq,
    output logic          dmemWe,
    output logic [N-1:0]  dmemAddr,
    output logic [N-1:0]  dmemWData,
    input  logic [N-1:0]  dmemRData,
    input  logic          dmemAck,
    output logic          wbValid,
    output logic          wbRegWrite,
    output logic [3:0]    wbRc,
    output logic [N-1:0]  wbData,
    output logic          branchTaken,
    output logic [N-1:0]  branchTarget,
    output logic          memError
);

    localparam int unsigned CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [0:0] {
        StIdle,
        StAccess
    } state_e;

    // Bundle field decode
    logic [N-1:0] rd3;
    logic [3:0]   rc;
    logic         regWrite;
    logic         memToReg;
    logic         memWrite;
    logic         branchFlag;
    logic         neg;
    logic         zero;
    logic [N-1:0] aluResult;
    logic [3:0]   opCode;
    logic [1:0]   unusedOpType;

    assign rd3          = exMemIn[N-1:0];
    assign rc           = exMemIn[N+3:N];
    assign regWrite     = exMemIn[N+4];
    assign memToReg     = exMemIn[N+5];
    assign memWrite     = exMemIn[N+6];
    assign branchFlag   = exMemIn[N+7];
    assign neg          = exMemIn[N+8];
    assign zero         = exMemIn[N+9];
    assign aluResult    = exMemIn[2*N+9:N+10];
    assign opCode       = exMemIn[2*N+13:2*N+10];
    assign unusedOpType = exMemIn[2*N+15:2*N+14];

    logic memOp;
    logic branchCond;

    assign memOp = memWrite | memToReg;

    always_comb begin
        branchCond = 1'b0;
        case (opCode)
            4'b0000: branchCond = 1'b1;
            4'b0001: branchCond = zero;
            4'b0010: branchCond = ~zero;
            4'b0011: branchCond = neg;
            4'b0100: branchCond = ~neg;
            default: branchCond = 1'b0;
        endcase
    end

    // State and holding registers
    state_e        stateQ, stateD;
    logic [CW-1:0] cntQ, cntD;
    logic          holdWeQ, holdWeD;
    logic [N-1:0]  holdAddrQ, holdAddrD;
    logic [N-1:0]  holdWDataQ, holdWDataD;
    logic [3:0]    holdRcQ, holdRcD;
    logic          holdRegWriteQ, holdRegWriteD;

    // Registered MEM/WB outputs
    logic          wbValidQ, wbValidD;
    logic          wbRegWriteQ, wbRegWriteD;
    logic [3:0]    wbRcQ, wbRcD;
    logic [N-1:0]  wbDataQ, wbDataD;
    logic          branchTakenQ, branchTakenD;
    logic [N-1:0]  branchTargetQ, branchTargetD;
    logic          memErrorQ, memErrorD;

    always_comb begin
        stateD        = stateQ;
        cntD          = cntQ;
        holdWeD       = holdWeQ;
        holdAddrD     = holdAddrQ;
        holdWDataD    = holdWDataQ;
        holdRcD       = holdRcQ;
        holdRegWriteD = holdRegWriteQ;
        wbValidD      = 1'b0;
        wbRegWriteD   = wbRegWriteQ;
        wbRcD         = wbRcQ;
        wbDataD       = wbDataQ;
        branchTakenD  = 1'b0;
        branchTargetD = branchTargetQ;
        memErrorD     = memErrorQ;

        unique case (stateQ)
            StIdle: begin
                if (inValid) begin
                    if (memOp) begin
                        // Store wins when both memory bits are set.
                        holdWeD       = memWrite;
                        holdAddrD     = aluResult;
                        holdWDataD    = rd3;
                        holdRcD       = rc;
                        holdRegWriteD = regWrite & ~memWrite;
                        cntD          = '0;
                        stateD        = StAccess;
                    end else begin
                        wbValidD    = 1'b1;
                        wbDataD     = aluResult;
                        wbRcD       = rc;
                        wbRegWriteD = regWrite;
                        if (branchFlag && branchCond) begin
                            branchTakenD  = 1'b1;
                            branchTargetD = aluResult;
                        end
                    end
                end
            end

            StAccess: begin
                if (dmemAck) begin
                    // An ack on the final counted cycle still completes normally.
                    wbValidD    = 1'b1;
                    wbRcD       = holdRcQ;
                    wbRegWriteD = holdRegWriteQ;
                    wbDataD     = holdWeQ ? holdAddrQ : dmemRData;
                    stateD      = StIdle;
                end else if (cntQ == CW'(TIMEOUT - 1)) begin
                    wbValidD    = 1'b1;
                    wbRcD       = holdRcQ;
                    wbRegWriteD = 1'b0;
                    memErrorD   = 1'b1;
                    stateD      = StIdle;
                end else begin
                    cntD = cntQ + CW'(1);
                end
            end

            default: stateD = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stateQ        <= StIdle;
            cntQ          <= '0;
            holdWeQ       <= 1'b0;
            holdAddrQ     <= '0;
            holdWDataQ    <= '0;
            holdRcQ       <= '0;
            holdRegWriteQ <= 1'b0;
            wbValidQ      <= 1'b0;
            wbRegWriteQ   <= 1'b0;
            wbRcQ         <= '0;
            wbDataQ       <= '0;
            branchTakenQ  <= 1'b0;
            branchTargetQ <= '0;
            memErrorQ     <= 1'b0;
        end else begin
            stateQ        <= stateD;
            cntQ          <= cntD;
            holdWeQ       <= holdWeD;
            holdAddrQ     <= holdAddrD;
            holdWDataQ    <= holdWDataD;
            holdRcQ       <= holdRcD;
            holdRegWriteQ <= holdRegWriteD;
            wbValidQ      <= wbValidD;
            wbRegWriteQ   <= wbRegWriteD;
            wbRcQ         <= wbRcD;
            wbDataQ       <= wbDataD;
            branchTakenQ  <= branchTakenD;
            branchTargetQ <= branchTargetD;
            memErrorQ     <= memErrorD;
        end
    end

    // Memory port and stall follow state directly so they drop on the completing edge.
    assign stall        = (stateQ == StAccess);
    assign dmemReq      = (stateQ == StAccess);
    assign dmemWe       = holdWeQ;
    assign dmemAddr     = holdAddrQ;
    assign dmemWData    = holdWDataQ;

    assign wbValid      = wbValidQ;
    assign wbRegWrite   = wbRegWriteQ;
    assign wbRc         = wbRcQ;
    assign wbData       = wbDataQ;
    assign branchTaken  = branchTakenQ;
    assign branchTarget = branchTargetQ;
    assign memError     = memErrorQ;

endmodule

// File: tb/tb_mem_access_stage.sv
// Self-checking bench for mem_access_stage: directed scenarios followed by random
// instruction streams checked against a transaction-level model.
module tb_mem_access_stage;

    localparam int N       = 24;
    localparam int BW      = 16 + 2 * N;
    localparam int TIMEOUT = 16;
    localparam int NO_ACK  = 1000;

    logic          clk = 1'b0;
    logic          rst;
    logic [BW-1:0] exMemIn;
    logic          inValid;
    logic          stall;
    logic          dmemReq;
    logic          dmemWe;
    logic [N-1:0]  dmemAddr;
    logic [N-1:0]  dmemWData;
    logic [N-1:0]  dmemRData;
    logic          dmemAck;
    logic          wbValid;
    logic          wbRegWrite;
    logic [3:0]    wbRc;
    logic [N-1:0]  wbData;
    logic          branchTaken;
    logic [N-1:0]  branchTarget;
    logic          memError;

    mem_access_stage #(
        .N       (N),
        .BW      (BW),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .exMemIn      (exMemIn),
        .inValid      (inValid),
        .stall        (stall),
        .dmemReq      (dmemReq),
        .dmemWe       (dmemWe),
        .dmemAddr     (dmemAddr),
        .dmemWData    (dmemWData),
        .dmemRData    (dmemRData),
        .dmemAck      (dmemAck),
        .wbValid      (wbValid),
        .wbRegWrite   (wbRegWrite),
        .wbRc         (wbRc),
        .wbData       (wbData),
        .branchTaken  (branchTaken),
        .branchTarget (branchTarget),
        .memError     (memError)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [N-1:0] rd3;
        logic [3:0]   rc;
        logic         regWrite;
        logic         memToReg;
        logic         memWrite;
        logic         branchFlag;
        logic         neg;
        logic         zero;
        logic [N-1:0] alu;
        logic [3:0]   opCode;
        logic [1:0]   opType;
    } instr_t;

    int   checks   = 0;
    int   failures = 0;
    logic expErr   = 1'b0;

    task automatic check1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
        end
    endtask

    task automatic checkN(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%06h expected=%06h", tag, obs, exp);
        end
    endtask

    task automatic checkI(input string tag, input int obs, input int exp);
        checks++;
        assert (obs == exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic logic [BW-1:0] pack(input instr_t i);
        return {i.opType, i.opCode, i.alu, i.zero, i.neg, i.branchFlag,
                i.memWrite, i.memToReg, i.regWrite, i.rc, i.rd3};
    endfunction

    // Branch rule for a non-memory instruction.
    function automatic logic taken(input instr_t i);
        if (!i.branchFlag) return 1'b0;
        if (i.opCode == 4'd0) return 1'b1;
        if (i.opCode == 4'd1) return i.zero;
        if (i.opCode == 4'd2) return !i.zero;
        if (i.opCode == 4'd3) return i.neg;
        if (i.opCode == 4'd4) return !i.neg;
        return 1'b0;
    endfunction

    function automatic logic [N-1:0] rndN();
        logic [31:0] r;
        r = $urandom;
        return r[N-1:0];
    endfunction

    function automatic instr_t randInstr(input int kind);
        instr_t   i;
        logic [31:0] r;
        r            = $urandom;
        i.rd3        = rndN();
        i.alu        = rndN();
        i.rc         = r[3:0];
        i.regWrite   = r[4];
        i.branchFlag = r[5];
        i.neg        = r[6];
        i.zero       = r[7];
        i.opCode     = {1'b0, r[10:8]};
        i.opType     = r[12:11];
        i.memToReg   = (kind == 1) || (kind == 3);
        i.memWrite   = (kind == 2) || (kind == 3);
        return i;
    endfunction

    function automatic instr_t blank();
        instr_t i;
        i = '{rd3: '0, rc: '0, regWrite: 1'b0, memToReg: 1'b0, memWrite: 1'b0,
              branchFlag: 1'b0, neg: 1'b0, zero: 1'b0, alu: '0, opCode: '0, opType: '0};
        return i;
    endfunction

    // Called at a negedge with the DUT idle; returns at the negedge the result is visible.
    task automatic runAlu(input string tag, input instr_t i);
        logic expTaken;
        expTaken = taken(i);
        exMemIn  = pack(i);
        inValid  = 1'b1;
        @(negedge clk);
        inValid = 1'b0;
        check1({tag, "_wbValid"}, wbValid, 1'b1);
        checkN({tag, "_wbData"}, wbData, i.alu);
        checkN({tag, "_wbRc"}, {20'd0, wbRc}, {20'd0, i.rc});
        check1({tag, "_wbRegWrite"}, wbRegWrite, i.regWrite);
        check1({tag, "_branchTaken"}, branchTaken, expTaken);
        if (expTaken) checkN({tag, "_branchTarget"}, branchTarget, i.alu);
        check1({tag, "_stall"}, stall, 1'b0);
        check1({tag, "_dmemReq"}, dmemReq, 1'b0);
        check1({tag, "_memError"}, memError, expErr);
    endtask

    task automatic runMem(input string tag, input instr_t i, input int ackDelay,
                          input logic [N-1:0] rdata);
        int   cycles;
        logic isStore;
        logic timedOut;
        isStore  = i.memWrite;
        timedOut = (ackDelay > TIMEOUT - 1);
        exMemIn  = pack(i);
        inValid  = 1'b1;
        check1({tag, "_stallAtCapture"}, stall, 1'b0);
        @(negedge clk);
        inValid = 1'b0;
        cycles  = 0;
        while (dmemReq === 1'b1 && cycles < 40) begin
            if (cycles == 0) begin
                checkN({tag, "_addr"}, dmemAddr, i.alu);
                check1({tag, "_we"}, dmemWe, isStore);
                if (isStore) checkN({tag, "_wdata"}, dmemWData, i.rd3);
            end
            check1({tag, "_stallBusy"}, stall, 1'b1);
            check1({tag, "_wbValidBusy"}, wbValid, 1'b0);
            if (cycles == ackDelay) begin
                dmemAck   = 1'b1;
                dmemRData = rdata;
            end
            @(negedge clk);
            dmemAck   = 1'b0;
            dmemRData = rndN();
            cycles++;
        end
        if (timedOut) expErr = 1'b1;
        checkI({tag, "_reqCycles"}, cycles, timedOut ? TIMEOUT : ackDelay + 1);
        check1({tag, "_wbValid"}, wbValid, 1'b1);
        check1({tag, "_stallDone"}, stall, 1'b0);
        check1({tag, "_wbRegWrite"}, wbRegWrite,
               (timedOut || isStore) ? 1'b0 : i.regWrite);
        if (!timedOut) begin
            checkN({tag, "_wbRc"}, {20'd0, wbRc}, {20'd0, i.rc});
            checkN({tag, "_wbData"}, wbData, isStore ? i.alu : rdata);
        end
        check1({tag, "_branchTaken"}, branchTaken, 1'b0);
        check1({tag, "_memError"}, memError, expErr);
    endtask

    task automatic idleCycle(input string tag, input logic strayAck);
        inValid = 1'b0;
        dmemAck = strayAck;
        @(negedge clk);
        dmemAck = 1'b0;
        check1({tag, "_wbValid"}, wbValid, 1'b0);
        check1({tag, "_branchTaken"}, branchTaken, 1'b0);
        check1({tag, "_stall"}, stall, 1'b0);
        check1({tag, "_dmemReq"}, dmemReq, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        instr_t i;
        int     kind;
        int     delay;
        logic [31:0] r;

        rst       = 1'b1;
        inValid   = 1'b0;
        exMemIn   = '0;
        dmemAck   = 1'b0;
        dmemRData = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check1("rst_wbValid", wbValid, 1'b0);
        check1("rst_stall", stall, 1'b0);
        check1("rst_dmemReq", dmemReq, 1'b0);
        check1("rst_dmemWe", dmemWe, 1'b0);
        checkN("rst_dmemAddr", dmemAddr, '0);
        checkN("rst_wbData", wbData, '0);
        check1("rst_branchTaken", branchTaken, 1'b0);
        check1("rst_memError", memError, 1'b0);
        rst = 1'b0;
        idleCycle("idle0", 1'b1);

        // Plain ALU op
        i = blank(); i.alu = 24'h000123; i.rc = 4'd5; i.regWrite = 1'b1;
        runAlu("alu", i);

        // Load with ack after 3 cycles
        i = blank(); i.alu = 24'h000040; i.rc = 4'd7; i.regWrite = 1'b1; i.memToReg = 1'b1;
        runMem("load3", i, 3, 24'h00BEEF);

        // Store acked the cycle req rises
        i = blank(); i.alu = 24'h000010; i.rd3 = 24'h0000AA; i.memWrite = 1'b1;
        i.regWrite = 1'b1; i.rc = 4'd2;
        runMem("store0", i, 0, 24'h123456);

        // Both memory bits set: store behaviour
        i = blank(); i.alu = 24'h000020; i.rd3 = 24'h00F00D; i.memWrite = 1'b1;
        i.memToReg = 1'b1; i.regWrite = 1'b1; i.rc = 4'd9;
        runMem("storeBoth", i, 2, 24'h0000EE);

        // Ack on the last counted cycle completes without error
        i = blank(); i.alu = 24'h000044; i.rc = 4'd3; i.regWrite = 1'b1; i.memToReg = 1'b1;
        runMem("loadEdge", i, TIMEOUT - 1, 24'h00CAFE);

        // No ack: timeout abort, sticky error, then a normal ALU op
        i = blank(); i.alu = 24'h000048; i.rc = 4'd4; i.regWrite = 1'b1; i.memToReg = 1'b1;
        runMem("loadTimeout", i, NO_ACK, 24'h0);
        i = blank(); i.alu = 24'h000777; i.rc = 4'd6; i.regWrite = 1'b1;
        runAlu("aluAfterTimeout", i);
        idleCycle("idleErr", 1'b0);
        check1("memErrorSticky", memError, 1'b1);

        // Branch on zero, taken then not taken, back to back
        i = blank(); i.alu = 24'h000200; i.branchFlag = 1'b1; i.opCode = 4'b0001; i.zero = 1'b1;
        runAlu("brZeroTaken", i);
        i.zero = 1'b0;
        runAlu("brZeroNot", i);

        // Reset during an access
        i = blank(); i.alu = 24'h000050; i.memToReg = 1'b1; i.regWrite = 1'b1;
        exMemIn = pack(i);
        inValid = 1'b1;
        @(negedge clk);
        inValid = 1'b0;
        repeat (2) @(negedge clk);
        check1("preRst_req", dmemReq, 1'b1);
        rst = 1'b1;
        @(negedge clk);
        check1("midRst_req", dmemReq, 1'b0);
        check1("midRst_stall", stall, 1'b0);
        check1("midRst_memError", memError, 1'b0);
        check1("midRst_wbValid", wbValid, 1'b0);
        rst    = 1'b0;
        expErr = 1'b0;
        idleCycle("postRst", 1'b0);

        // Random instruction stream
        for (int n = 0; n < 80; n++) begin
            r    = $urandom;
            kind = (r[1:0] == 2'd0) ? int'(r[3:2]) : 0;
            i    = randInstr(kind);
            if (kind == 0) begin
                runAlu("rndAlu", i);
            end else begin
                delay = (r[7:4] == 4'd0) ? NO_ACK : int'($urandom_range(0, 6));
                runMem("rndMem", i, delay, rndN());
            end
            if (r[8] && r[9]) idleCycle("rndIdle", r[10]);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
